button_inc_pulser: RTL and testbench

//  Conditions a raw push-button into single-cycle increment strobes for nbit_counter_inc.inc.

---
 rtl/button_inc_pulser_if.sv | 22 ++
 rtl/button_inc_pulser.sv | 125 ++++++++++++
 tb/tb_button_inc_pulser.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/button_inc_pulser_if.sv
// Button pin and conditioned outputs of one button_inc_pulser instance.
// master drives the raw pin and observes the strobes; slave is the pulser.
interface button_inc_pulser_if;
  logic btn_in;
  logic inc;
  logic btn_level;
  logic repeating;

  modport master (
    output btn_in,
    input  inc,
    input  btn_level,
    input  repeating
  );

  modport slave (
    input  btn_in,
    output inc,
    output btn_level,
    output repeating
  );
endinterface

// File: rtl/button_inc_pulser.sv
// Turns a raw push-button into single-cycle increment strobes:
// synchroniser, debounce, one pulse per press and optional auto-repeat while held.
module button_inc_pulser #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 100_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input logic                clk,
  input logic                reset_n,
  button_inc_pulser_if.slave btn
);

  localparam int unsigned MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC) + 1;

  // The entry sample is taken in the previous state, so the wait states need D-1 more samples.
  localparam int unsigned DEB_LAST_I = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [TW-1:0] DEB_LAST  = TW'(DEB_LAST_I);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] S_HELD         = 3'd2;
  localparam logic [2:0] S_REPEAT       = 3'd3;
  localparam logic [2:0] S_RELEASE_WAIT = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [2:0]             state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d, timer_inc;
  logic                   inc_q, inc_d;
  logic                   level_q, level_d;
  logic                   rep_q, rep_d;
  logic [2:0]             release_state;

  assign btn_sync      = sync_q[SYNC_STAGES-1];
  assign timer_inc     = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
  assign release_state = (DEBOUNCE_CYCLES == 1) ? S_IDLE : S_RELEASE_WAIT;

  always_comb begin
    state_d = state_q;
    timer_d = timer_inc;
    inc_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = S_HELD;
            inc_d   = 1'b1;
          end else begin
            state_d = S_PRESS_WAIT;
          end
        end
      end
      S_PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = S_IDLE;
        end else if (timer_q >= DEB_LAST) begin
          state_d = S_HELD;
          inc_d   = 1'b1;
        end
      end
      S_HELD: begin
        if (!btn_sync) begin
          state_d = release_state;
        end else if (REPEAT_EN && (timer_q >= HOLD_LAST)) begin
          state_d = S_REPEAT;
          inc_d   = 1'b1;
        end
      end
      S_REPEAT: begin
        // Release takes priority over a coincident repeat pulse.
        if (!btn_sync) begin
          state_d = release_state;
        end else if (timer_q >= REP_LAST) begin
          inc_d   = 1'b1;
          timer_d = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = S_HELD;
        end else if (timer_q >= DEB_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  always_comb begin
    level_d = (state_d == S_HELD) || (state_d == S_REPEAT) || (state_d == S_RELEASE_WAIT);
    rep_d   = (state_d == S_REPEAT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= S_IDLE;
      timer_q <= '0;
      inc_q   <= 1'b0;
      level_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn.btn_in};
      state_q <= state_d;
      timer_q <= timer_d;
      inc_q   <= inc_d;
      level_q <= level_d;
      rep_q   <= rep_d;
    end
  end

  assign btn.inc       = inc_q;
  assign btn.btn_level = level_q;
  assign btn.repeating = rep_q;

endmodule

// File: tb/tb_button_inc_pulser.sv
// Directed bench for button_inc_pulser: per-cycle vector table on a repeat-enabled
// instance, plus a 17-press bouncy sequence on a repeat-disabled instance.
module tb_button_inc_pulser;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  button_inc_pulser_if if1 ();
  button_inc_pulser_if if2 ();

  button_inc_pulser #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .REPEAT_EN      (1'b1)
  ) dut1 (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (if1)
  );

  button_inc_pulser #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .REPEAT_EN      (1'b0)
  ) dut2 (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (if2)
  );

  typedef struct {
    logic btn;
    logic rst_n;
    logic exp_inc;
    logic exp_lvl;
    logic exp_rep;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   incs2;
  logic [3:0] count4;
  logic rep_seen2;

  // Append n identical cycles: inputs driven in a cycle, outputs expected in that same cycle.
  task automatic add(input int n, input logic b, input logic r, input logic [2:0] e);
    vec_t v;
    v.btn = b;
    v.rst_n = r;
    v.exp_inc = e[2];
    v.exp_lvl = e[1];
    v.exp_rep = e[0];
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic drive2(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 if2.btn_in = b;
      @(negedge clk);
      if (if2.inc) begin
        incs2++;
        count4 = count4 + 4'd1;
      end
      if (if2.repeating) rep_seen2 = 1'b1;
    end
  endtask

  initial begin
    logic [2:0] got, exp;
    if1.btn_in = 1'b0;
    if2.btn_in = 1'b0;

    // Reset state, then idle
    add(2, 1'b0, 1'b1, 3'b000);
    // Clean press and release
    add(6, 1'b1, 1'b1, 3'b000);
    add(1, 1'b1, 1'b1, 3'b110);
    add(6, 1'b0, 1'b1, 3'b010);
    add(3, 1'b0, 1'b1, 3'b000);
    // Bounce on press
    add(3, 1'b1, 1'b1, 3'b000);
    add(1, 1'b0, 1'b1, 3'b000);
    add(6, 1'b1, 1'b1, 3'b000);
    add(1, 1'b1, 1'b1, 3'b110);
    add(6, 1'b0, 1'b1, 3'b010);
    add(3, 1'b0, 1'b1, 3'b000);
    // Hold into auto-repeat, release coincident-free
    add(6, 1'b1, 1'b1, 3'b000);
    add(1, 1'b1, 1'b1, 3'b110);
    add(9, 1'b1, 1'b1, 3'b010);
    add(1, 1'b1, 1'b1, 3'b111);
    add(2, 1'b1, 1'b1, 3'b011);
    add(1, 1'b1, 1'b1, 3'b111);
    add(2, 1'b1, 1'b1, 3'b011);
    add(1, 1'b1, 1'b1, 3'b111);
    add(2, 1'b0, 1'b1, 3'b011);
    add(1, 1'b0, 1'b1, 3'b111);
    add(3, 1'b0, 1'b1, 3'b010);
    add(3, 1'b0, 1'b1, 3'b000);
    // Release glitch: back to HELD without a pulse
    add(6, 1'b1, 1'b1, 3'b000);
    add(1, 1'b1, 1'b1, 3'b110);
    add(3, 1'b1, 1'b1, 3'b010);
    add(2, 1'b0, 1'b1, 3'b010);
    add(4, 1'b1, 1'b1, 3'b010);
    add(6, 1'b0, 1'b1, 3'b010);
    add(3, 1'b0, 1'b1, 3'b000);
    // Reset on the edge a repeat pulse is due, button still held
    add(6, 1'b1, 1'b1, 3'b000);
    add(1, 1'b1, 1'b1, 3'b110);
    add(9, 1'b1, 1'b1, 3'b010);
    add(1, 1'b1, 1'b1, 3'b111);
    add(1, 1'b1, 1'b1, 3'b011);
    add(1, 1'b1, 1'b0, 3'b011);
    add(6, 1'b1, 1'b1, 3'b000);
    add(1, 1'b1, 1'b1, 3'b110);
    add(6, 1'b0, 1'b1, 3'b010);
    add(3, 1'b0, 1'b1, 3'b000);

    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      if1.btn_in = vecs[i].btn;
      reset_n    = vecs[i].rst_n;
      @(negedge clk);
      got = {if1.inc, if1.btn_level, if1.repeating};
      exp = {vecs[i].exp_inc, vecs[i].exp_lvl, vecs[i].exp_rep};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d {inc,level,repeating} got %b expected %b", i, got, exp);
      end
    end

    // Repeat-disabled instance: 17 bouncy presses, each held past HOLD_CYCLES
    count4 = 4'd0;
    rep_seen2 = 1'b0;
    for (int p = 0; p < 17; p++) begin
      incs2 = 0;
      drive2(1'b1, 1);
      drive2(1'b0, 1);
      drive2(1'b1, 1);
      drive2(1'b0, 1);
      drive2(1'b1, 20);
      drive2(1'b0, 1);
      drive2(1'b1, 1);
      drive2(1'b0, 12);
      checks++;
      if (incs2 != 1) begin
        errors++;
        $display("FAIL press%0d inc count got %0d expected 1", p, incs2);
      end
    end
    checks++;
    if (count4 !== 4'd1) begin
      errors++;
      $display("FAIL counter4 got %0d expected 1", count4);
    end
    checks++;
    if (rep_seen2 !== 1'b0) begin
      errors++;
      $display("FAIL norepeat repeating got %b expected 0", rep_seen2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
